// File: rtl/digital_clock_cfg.sv
// rtl/digital_clock_cfg.sv - configurable BCD hh:mm:ss clock with prescaler, 12/24h display, load and alarm
module digital_clock_cfg #(
   parameter int TICK_DIV = 1,
   parameter int DIV_W    = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       mode_12,
   input  logic       load,
   input  logic [4:0] ld_h,
   input  logic [5:0] ld_m,
   input  logic [5:0] ld_s,
   input  logic       alarm_en,
   input  logic [4:0] al_h,
   input  logic [5:0] al_m,
   output logic [3:0] s0,
   output logic [3:0] s1,
   output logic [3:0] m0,
   output logic [3:0] m1,
   output logic [3:0] h0,
   output logic [3:0] h1,
   output logic       pm,
   output logic       sec_tick,
   output logic       alarm,
   output logic       load_err
);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [4:0]       hr;
   logic [3:0]       sec_u, sec_t, min_u, min_t;
   logic [4:0]       n_hr;
   logic [3:0]       n_su, n_st, n_mu, n_mt;
   logic             at_wrap, tick, advance, ld_ok, al_hit;
   logic [5:0]       n_min_bin;
   logic [4:0]       disp_h;

   assign at_wrap = (div_cnt == DIV_MAX);
   assign tick    = en && at_wrap;
   assign advance = tick && !load;
   assign ld_ok   = (ld_h <= 5'd23) && (ld_m <= 6'd59) && (ld_s <= 6'd59);

   // Full carry chain resolved in one step so wrap-arounds never show intermediates.
   always_comb begin
      n_su = sec_u + 4'd1;
      n_st = sec_t;
      n_mu = min_u;
      n_mt = min_t;
      n_hr = hr;
      if (sec_u == 4'd9) begin
         n_su = 4'd0;
         n_st = sec_t + 4'd1;
         if (sec_t == 4'd5) begin
            n_st = 4'd0;
            n_mu = min_u + 4'd1;
            if (min_u == 4'd9) begin
               n_mu = 4'd0;
               n_mt = min_t + 4'd1;
               if (min_t == 4'd5) begin
                  n_mt = 4'd0;
                  n_hr = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
               end
            end
         end
      end
   end

   assign n_min_bin = {2'b00, n_mt} * 6'd10 + {2'b00, n_mu};
   assign al_hit    = alarm_en && (al_h <= 5'd23) && (al_m <= 6'd59) &&
                      (n_hr == al_h) && (n_min_bin == al_m) &&
                      (n_st == 4'd0) && (n_su == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         hr       <= '0;
         sec_u    <= '0;
         sec_t    <= '0;
         min_u    <= '0;
         min_t    <= '0;
         sec_tick <= 1'b0;
         alarm    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         alarm    <= 1'b0;
         load_err <= load && !ld_ok;
         if (load && ld_ok) begin
            hr      <= ld_h;
            min_t   <= 4'(ld_m / 6'd10);
            min_u   <= 4'(ld_m % 6'd10);
            sec_t   <= 4'(ld_s / 6'd10);
            sec_u   <= 4'(ld_s % 6'd10);
            div_cnt <= '0;
         end else begin
            if (en)
               div_cnt <= at_wrap ? '0 : div_cnt + DIV_W'(1);
            if (advance) begin
               hr       <= n_hr;
               min_t    <= n_mt;
               min_u    <= n_mu;
               sec_t    <= n_st;
               sec_u    <= n_su;
               sec_tick <= 1'b1;
               alarm    <= al_hit;
            end
         end
      end
   end

   // 12h view: midnight hour reads 12, afternoon hours fold down by 12.
   always_comb begin
      disp_h = hr;
      if (mode_12) begin
         if (hr == 5'd0)
            disp_h = 5'd12;
         else if (hr > 5'd12)
            disp_h = hr - 5'd12;
      end
      if (disp_h >= 5'd20) begin
         h1 = 4'd2;
         h0 = 4'(disp_h - 5'd20);
      end else if (disp_h >= 5'd10) begin
         h1 = 4'd1;
         h0 = 4'(disp_h - 5'd10);
      end else begin
         h1 = 4'd0;
         h0 = 4'(disp_h);
      end
   end

   assign pm = (hr >= 5'd12);
   assign s0 = sec_u;
   assign s1 = sec_t;
   assign m0 = min_u;
   assign m1 = min_t;

endmodule

// File: doc/digital_clock_cfg.md
Name: digital_clock_cfg

Overview:
- Configurable successor to the existing fixed BCD hh:mm:ss counter.
- Adds a runtime 12/24-hour mode with a PM flag, and a parametrised prescaler so the clock can run from a fast system clock.
- Adds a synchronous time-load (set) port with range checking, and a minute-resolution alarm with a one-cycle pulse.
- Sits between the system clock domain and the display/driver logic; all six BCD digit outputs feed the seven-segment mux.

Parameters:
- TICK_DIV, default 1: clk cycles per one-second tick; must be >= 1. A value of 1 advances one second per enabled clk.
- DIV_W, default 32: prescaler counter width; must satisfy 2**DIV_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; low freezes the prescaler and time.
- mode_12  input  1  1 = 12-hour display, 0 = 24-hour display.
- load  input  1  one-cycle strobe that loads ld_h/ld_m/ld_s.
- ld_h  input  5  load hour, binary 0..23.
- ld_m  input  6  load minute, binary 0..59.
- ld_s  input  6  load second, binary 0..59.
- alarm_en  input  1  alarm arm.
- al_h  input  5  alarm hour, binary 0..23.
- al_m  input  6  alarm minute, binary 0..59.
- s0, s1, m0, m1, h0, h1  output  4 each  BCD digits (units and tens of seconds, minutes, hours).
- pm  output  1  1 when internal hour is 12..23; valid in both modes.
- sec_tick  output  1  one-cycle pulse each time time advances.
- alarm  output  1  one-cycle alarm pulse.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Internal time is 00:00:00 and the prescaler is 0.
  - sec_tick, alarm and load_err are 0.
  - Digits show 00:00:00 in 24h mode; in 12h mode they show 12:00:00 with pm=0.
- Internal state:
  - Hour is binary 0..23.
  - Minutes and seconds are held as BCD digit registers.
  - Display digits are a combinational decode of internal state plus mode_12, with zero latency.
  - Changing mode_12 alters only the display, never the stored time.
- 12h decode: internal hour 0 shows 12; hours 1..12 show as-is; hours 13..23 show hour-12. Leading tens digit is 0 (01..09) in both modes.
- Prescaler:
  - When en=1, it increments each clk.
  - At TICK_DIV-1 it wraps to 0 and asserts sec_tick that same cycle, and time advances on that edge.
  - When en=0, the prescaler holds and no tick occurs.
- Advance chain:
  - s0 9->0 carries into s1; s1 5->0 carries into m0; m0 9->0 carries into m1; m1 5->0 carries into the hour.
  - Hour 23->0 wraps. 23:59:59 -> 00:00:00 in a single edge; no intermediate values are visible.
- Load:
  - Valid when ld_h<=23, ld_m<=59 and ld_s<=59.
  - A valid load writes the time on the next edge (converting minutes and seconds to BCD) and clears the prescaler to 0.
  - An invalid load leaves time unchanged and pulses load_err for one cycle.
  - Load has priority: a load coinciding with a tick suppresses that tick's advance and its sec_tick.
  - Load works regardless of en.
- Alarm:
  - Pulses for one cycle on the edge where a tick advances time into al_h:al_m:00 while alarm_en=1.
  - Loading a matching time does not fire the alarm.
  - Out-of-range al_h/al_m never match.
  - Deasserting alarm_en after the pulse has no effect.
- Reset mid-operation forces the reset values immediately, independent of clk.

Test Plan:
- Reset with TICK_DIV=1, en=1, mode_12=0, for 86400 ticks -> digits return to 00:00:00. Check 09:59:59->10:00:00 and 23:59:59->00:00:00 transitions exactly.
- Load 13:05:00 with mode_12=1 -> h1h0=01, pm=1. Set mode_12=0 -> h1h0=13, time unchanged. Load 00:00:00 in 12h mode -> 12:00:00, pm=0.
- TICK_DIV=4: en=1 for 12 cycles -> sec_tick exactly every 4th cycle and s0=3. Drop en for 5 cycles -> no change. Load mid-count -> the next tick comes 4 cycles after load.
- Load ld_h=24 (also ld_m=60) -> load_err pulses once, time unchanged. Load coincident with tick -> loaded value shown, no sec_tick, no extra advance.
- alarm_en=1, al=07:30, load 07:29:58 -> alarm pulses exactly once, on the 07:29:59->07:30:00 edge. Load 07:30:00 directly -> no alarm.
- Assert rst_n=0 asynchronously between clk edges during running time -> outputs reach reset values before the next clk edge.
